// File: rtl/uart_pkg.sv
// Shared types and line-level constants for the UART transmit path.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   localparam logic PAR_EVEN  = 1'b0;
   localparam logic PAR_ODD   = 1'b1;
   localparam logic START_BIT = 1'b0;
   localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Parallel-load, shift-right register presenting the payload LSB first.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  shift,
   input  logic [DATA_WIDTH-1:0] data,
   output logic                  cur_bit,
   output logic                  next_bit
);

   logic [DATA_WIDTH-1:0] shift_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         shift_reg <= '0;
      end else if (load) begin
         shift_reg <= data;
      end else if (shift) begin
         shift_reg <= {1'b0, shift_reg[DATA_WIDTH-1:1]};
      end
   end

   // next_bit lets the FSM register the upcoming line level on the shift edge
   assign cur_bit  = shift_reg[0];
   assign next_bit = shift_reg[1];

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bit.
module uart_tx
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_typ,
   output logic                  tx_out,
   output logic                  busy
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W = $clog2(DATA_WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cycle_cnt;
   logic [BIT_W-1:0] bit_cnt;
   logic             par_en_q;
   logic             par_bit_q;
   logic             accept;
   logic             bit_done;
   logic             cur_bit;
   logic             next_bit;

   assign accept   = (state == IDLE) && data_valid;
   assign bit_done = (state != IDLE) && (cycle_cnt == LAST_CYCLE);

   uart_tx_serializer #(
      .DATA_WIDTH(DATA_WIDTH)
   ) u_serializer (
      .clk     (clk),
      .rst     (rst),
      .load    (accept),
      .shift   ((state == DATA) && bit_done),
      .data    (data_in),
      .cur_bit (cur_bit),
      .next_bit(next_bit)
   );

   // tx_out is loaded with the level of the state being entered, so the line
   // changes exactly on the edge that changes state and never glitches
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cycle_cnt <= '0;
         bit_cnt   <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         tx_out    <= STOP_BIT;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx_out    <= STOP_BIT;
               busy      <= 1'b0;
               cycle_cnt <= '0;
               bit_cnt   <= '0;
               if (accept) begin
                  state     <= START;
                  tx_out    <= START_BIT;
                  busy      <= 1'b1;
                  par_en_q  <= par_en;
                  par_bit_q <= (^data_in) ^ (par_typ == PAR_ODD);
               end
            end
            default: begin
               if (!bit_done) begin
                  cycle_cnt <= cycle_cnt + 1'b1;
               end else begin
                  cycle_cnt <= '0;
                  case (state)
                     START: begin
                        state  <= DATA;
                        tx_out <= cur_bit;
                     end
                     DATA: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
                           if (par_en_q) begin
                              state  <= PARITY;
                              tx_out <= par_bit_q;
                           end else begin
                              state  <= STOP;
                              tx_out <= STOP_BIT;
                           end
                        end else begin
                           tx_out <= next_bit;
                        end
                     end
                     PARITY: begin
                        state  <= STOP;
                        tx_out <= STOP_BIT;
                     end
                     default: begin
                        state  <= IDLE;
                        tx_out <= STOP_BIT;
                        busy   <= 1'b0;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, a line monitor
// deserializes tx_out and checks every cycle of each frame against them.
module tb_uart_tx;

   localparam int CPB = 4;

   logic       clk;
   logic       rst;
   logic [7:0] data_in;
   logic       data_valid;
   logic       par_en;
   logic       par_typ;
   logic       tx_out;
   logic       busy;

   typedef struct {
      logic [7:0] data;
      logic       par_en;
      logic       par_bit;
   } frame_t;

   frame_t exp_q[$];
   int     errors = 0;
   int     checks = 0;
   int     frames_pushed = 0;
   int     frames_seen = 0;
   logic   mon_en = 1'b1;

   uart_tx #(
      .DATA_WIDTH  (8),
      .CLKS_PER_BIT(CPB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .data_in   (data_in),
      .data_valid(data_valid),
      .par_en    (par_en),
      .par_typ   (par_typ),
      .tx_out    (tx_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Issue one request on a negedge while idle; exp_par is the hand-computed parity bit
   task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt,
                                input logic exp_par, input bit push);
      checkOutput("pre_accept_busy", busy, 0);
      data_in    = d;
      par_en     = pe;
      par_typ    = pt;
      data_valid = 1'b1;
      if (push) begin
         exp_q.push_back('{data: d, par_en: pe, par_bit: exp_par});
         frames_pushed++;
      end
      @(negedge clk);
      data_valid = 1'b0;
      checkOutput("accept_busy_rise", busy, 1);
      checkOutput("accept_start_bit", tx_out, 0);
   endtask

   task automatic wait_idle();
      int budget;
      budget = 0;
      while (busy && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 200) checkOutput("timeout_idle", busy, 0);
      repeat (2) @(negedge clk);
   endtask

   // Line monitor: on a start bit, pop the expected frame and compare every cycle
   initial begin
      frame_t     f;
      int         nb;
      logic [10:0] line;
      int         line_err;
      int         busy_err;
      logic [7:0] rx;
      logic       rx_par;
      logic       rx_stop;
      forever begin
         @(negedge clk);
         if (mon_en && rst && tx_out == 1'b0) begin
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_frame", 1, 0);
               for (int i = 0; i < 200 && busy; i++) @(negedge clk);
            end else begin
               f        = exp_q.pop_front();
               nb       = f.par_en ? 11 : 10;
               line     = {1'b1, (f.par_en ? f.par_bit : 1'b1), f.data, 1'b0};
               line_err = 0;
               busy_err = 0;
               rx       = 8'h00;
               rx_par   = 1'b0;
               rx_stop  = 1'b0;
               for (int c = 0; c < nb * CPB; c++) begin
                  if (c > 0) @(negedge clk);
                  if (tx_out !== line[c / CPB]) line_err++;
                  if (busy !== 1'b1) busy_err++;
                  if (c % CPB == CPB / 2) begin
                     if (c / CPB >= 1 && c / CPB <= 8) rx[c / CPB - 1] = tx_out;
                     else if (f.par_en && c / CPB == 9) rx_par = tx_out;
                     else if (c / CPB == nb - 1) rx_stop = tx_out;
                  end
               end
               @(negedge clk);
               checkOutput("frame_line", line_err, 0);
               checkOutput("frame_busy_len", busy_err, 0);
               checkOutput("frame_data", rx, f.data);
               if (f.par_en) checkOutput("frame_parity", rx_par, f.par_bit);
               checkOutput("frame_stop", rx_stop, 1);
               checkOutput("gap_busy", busy, 0);
               checkOutput("gap_tx", tx_out, 1);
               frames_seen++;
            end
         end
      end
   end

   initial begin
      int idle;
      int bad;
      rst        = 1'b1;
      data_in    = 8'h00;
      data_valid = 1'b0;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_tx", tx_out, 1);
      checkOutput("reset_busy", busy, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] basic frame 0xA5, no parity");
      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1);
      wait_idle();

      $display("[TB] parity frames 0x0F even/odd");
      applyStimulus(8'h0F, 1'b1, 1'b0, 1'b0, 1);
      wait_idle();
      applyStimulus(8'h0F, 1'b1, 1'b1, 1'b1, 1);
      wait_idle();

      $display("[TB] request while busy is ignored");
      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 1);
      repeat (10) @(negedge clk);
      data_in    = 8'h3C;
      data_valid = 1'b1;
      @(negedge clk);
      data_valid = 1'b0;
      wait_idle();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (busy) bad++;
      end
      checkOutput("no_second_frame", bad, 0);

      $display("[TB] reset during data bit 3");
      mon_en = 1'b0;
      applyStimulus(8'hA5, 1'b0, 1'b0, 1'b0, 0);
      repeat (17) @(negedge clk);
      checkOutput("bit3_before_reset", tx_out, 0);
      #1 rst = 1'b0;
      #1;
      checkOutput("reset_async_tx", tx_out, 1);
      checkOutput("reset_async_busy", busy, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy || !tx_out) bad++;
      end
      checkOutput("idle_after_reset", bad, 0);
      mon_en = 1'b1;

      $display("[TB] back-to-back 0x55 then 0xAA");
      data_in    = 8'h55;
      par_en     = 1'b0;
      par_typ    = 1'b0;
      data_valid = 1'b1;
      exp_q.push_back('{data: 8'h55, par_en: 1'b0, par_bit: 1'b0});
      exp_q.push_back('{data: 8'hAA, par_en: 1'b0, par_bit: 1'b0});
      frames_pushed += 2;
      @(negedge clk);
      checkOutput("b2b_first_accept", busy, 1);
      data_in = 8'hAA;
      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
      idle = 0;
      while (!busy && idle < 50) begin
         idle++;
         @(negedge clk);
      end
      data_valid = 1'b0;
      checkOutput("b2b_gap", idle, 1);
      wait_idle();

      $display("[TB] mid-frame config change on 0x81");
      applyStimulus(8'h81, 1'b1, 1'b0, 1'b0, 1);
      repeat (10) @(negedge clk);
      data_in = 8'h7E;
      par_typ = 1'b1;
      par_en  = 1'b0;
      wait_idle();

      repeat (5) @(negedge clk);
      checkOutput("queue_empty", exp_q.size(), 0);
      checkOutput("frames_seen", frames_seen, frames_pushed);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
